// File: rtl/parity_check_64.sv
// Receive-side parity checker: a 2-stage valid/ready pipeline recomputes parity over each word,
// flags mismatches, and keeps a sticky error flag plus a saturating error count.
module parity_check_64 #(
   parameter int unsigned W     = 64,
   parameter bit          ODD   = 1'b0,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_par,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             clr_err
);

   logic             s1_valid_q, s1_valid_d;
   logic [W-1:0]     s1_data_q, s1_data_d;
   logic             s1_par_q, s1_par_d;
   logic             s2_valid_q, s2_valid_d;
   logic [W-1:0]     s2_data_q, s2_data_d;
   logic             s2_err_q, s2_err_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic s1_rdy, s2_rdy;
   logic in_hs, s1_to_s2, out_err_hs;
   logic mis;

   assign s2_rdy   = !s2_valid_q || out_ready;
   assign s1_rdy   = !s1_valid_q || s2_rdy;
   assign in_ready = s1_rdy;

   assign in_hs      = in_valid && s1_rdy;
   assign s1_to_s2   = s1_valid_q && s2_rdy;
   assign out_err_hs = s2_valid_q && out_ready && s2_err_q;

   assign mis = (^s1_data_q) ^ s1_par_q ^ ODD;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_par_d   = s1_par_q;
      if (s1_rdy) begin
         s1_valid_d = in_valid;
      end
      if (in_hs) begin
         s1_data_d = in_data;
         s1_par_d  = in_par;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_err_d   = s2_err_q;
      if (s2_rdy) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_to_s2) begin
         s2_data_d = s1_data_q;
         s2_err_d  = mis;
      end
   end

   // A clear coinciding with an erroneous handshake wins; that event is dropped.
   always_comb begin
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
      if (clr_err) begin
         err_sticky_d = 1'b0;
         err_cnt_d    = '0;
      end else if (out_err_hs) begin
         err_sticky_d = 1'b1;
         if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_par_q     <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_data_q    <= '0;
         s2_err_q     <= 1'b0;
         err_sticky_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         s1_par_q     <= s1_par_d;
         s2_valid_q   <= s2_valid_d;
         s2_data_q    <= s2_data_d;
         s2_err_q     <= s2_err_d;
         err_sticky_q <= err_sticky_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_data   = s2_data_q;
   assign out_err    = s2_err_q;
   assign err_sticky = err_sticky_q;
   assign err_cnt    = err_cnt_q;

endmodule
